// File: rtl/packet_assembler.sv
// Serialises a typed packet (header, source, destination, payload) into words over a valid/ready link.
// Optional macro PKT_CHECKSUM_EN appends a trailing XOR checksum word.
module packet_assembler #(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned PAYLOAD_WORDS = 4
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                tx_req,
    input  logic [2:0]                          tx_type,
    input  logic [WORD_WIDTH-1:0]               myNodeID,
    input  logic [WORD_WIDTH-1:0]               destinationID,
    input  logic [PAYLOAD_WORDS*WORD_WIDTH-1:0] payload,
    output logic [WORD_WIDTH-1:0]               out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                tx_busy,
    output logic                                tx_done,
    output logic                                tx_err
);

    localparam int unsigned PL_W  = PAYLOAD_WORDS * WORD_WIDTH;
    localparam int unsigned IDX_W = 4;
`ifdef PKT_CHECKSUM_EN
    localparam int unsigned CSUM_WORDS = 1;
`else
    localparam int unsigned CSUM_WORDS = 0;
`endif
    localparam logic [2:0] TYPE_INVALID = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Total words on the wire for a packet type, header included.
    function automatic logic [7:0] f_count(input logic [2:0] t);
        logic [7:0] base;
        case (t)
            3'b000:  base = 8'd7;
            3'b001:  base = 8'd4;
            3'b010:  base = 8'd6;
            3'b011:  base = 8'd5;
            3'b100:  base = 8'd4;
            3'b101:  base = 8'd6;
            3'b110:  base = 8'd6;
            default: base = 8'd0;
        endcase
        return base + 8'(CSUM_WORDS);
    endfunction

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_dst;
    logic [PL_W-1:0]       r_payload;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_last_idx;
    logic [WORD_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
`ifdef PKT_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_csum;
    logic [WORD_WIDTH-1:0] w_csum_nxt;
`endif

    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] w_src_nxt;
    logic [WORD_WIDTH-1:0] w_dst_nxt;
    logic [PL_W-1:0]       w_payload_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      w_last_idx_nxt;
    logic [WORD_WIDTH-1:0] w_out_data_nxt;
    logic                  w_out_valid_nxt;
    logic                  w_out_last_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic [7:0]            w_cnt;
    logic [WORD_WIDTH-1:0] w_hdr;
    logic [IDX_W-1:0]      w_nidx;
    logic [WORD_WIDTH-1:0] w_nword;

    assign w_cnt = f_count(tx_type);
    assign w_hdr = WORD_WIDTH'({tx_type, 5'b0, w_cnt});

    // Word that follows the one currently presented, taken from the latched fields.
    always_comb begin
        w_nidx  = r_idx + IDX_W'(1);
        w_nword = '0;
        if (w_nidx == IDX_W'(1)) begin
            w_nword = r_src;
        end else if (w_nidx == IDX_W'(2)) begin
            w_nword = r_dst;
        end
        for (int unsigned k = 0; k < PAYLOAD_WORDS; k++) begin
            if (w_nidx == IDX_W'(k + 3)) begin
                w_nword = r_payload[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
`ifdef PKT_CHECKSUM_EN
        if (w_nidx == r_last_idx) begin
            w_nword = r_csum;
        end
`endif
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_src_nxt       = r_src;
        w_dst_nxt       = r_dst;
        w_payload_nxt   = r_payload;
        w_idx_nxt       = r_idx;
        w_last_idx_nxt  = r_last_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
`ifdef PKT_CHECKSUM_EN
        w_csum_nxt      = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_nxt      = 1'b0;
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
                if (tx_req) begin
                    if (tx_type == TYPE_INVALID) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_SEND;
                        w_src_nxt       = myNodeID;
                        w_dst_nxt       = destinationID;
                        w_payload_nxt   = payload;
                        w_idx_nxt       = '0;
                        w_last_idx_nxt  = IDX_W'(w_cnt - 8'd1);
                        w_out_data_nxt  = w_hdr;
                        w_out_valid_nxt = 1'b1;
                        w_busy_nxt      = 1'b1;
`ifdef PKT_CHECKSUM_EN
                        w_csum_nxt      = w_hdr;
`endif
                    end
                end
            end
            S_SEND: begin
                if (r_out_valid && out_ready) begin
                    if (r_idx == r_last_idx) begin
                        w_state_nxt     = S_DONE;
                        w_out_data_nxt  = '0;
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_busy_nxt      = 1'b1;
                    end else begin
                        w_idx_nxt      = w_nidx;
                        w_out_data_nxt = w_nword;
                        w_out_last_nxt = (w_nidx == r_last_idx);
`ifdef PKT_CHECKSUM_EN
                        w_csum_nxt     = r_csum ^ w_nword;
`endif
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_payload   <= '0;
            r_idx       <= '0;
            r_last_idx  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_payload   <= w_payload_nxt;
            r_idx       <= w_idx_nxt;
            r_last_idx  <= w_last_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
`ifdef PKT_CHECKSUM_EN
            r_csum      <= w_csum_nxt;
`endif
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;
    assign tx_err    = r_err;

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: expected-word queue model plus per-cycle output checker.
module tb_packet_assembler;

`ifdef PKT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        tx_req;
    logic [2:0]  tx_type;
    logic [15:0] myNodeID;
    logic [15:0] destinationID;
    logic [63:0] payload;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_err;

    packet_assembler #(.WORD_WIDTH(16), .PAYLOAD_WORDS(4)) dut (
        .clk(clk), .nrst(nrst), .tx_req(tx_req), .tx_type(tx_type),
        .myNodeID(myNodeID), .destinationID(destinationID), .payload(payload),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rx_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          done_due = 0;
    bit          after_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet contents straight from the layout rules: header, ids, N payload words, optional XOR.
    task automatic push_pkt(input logic [2:0] t, input logic [15:0] s, input logic [15:0] d,
                            input logic [63:0] p);
        int          n_pl[7] = '{4, 1, 3, 2, 1, 3, 3};
        int          cnt;
        logic [15:0] words[$];
        logic [15:0] x;
        exp_t        e;
        cnt = 3 + n_pl[t] + CS;
        words.push_back({t, 5'b0, 8'(cnt)});
        words.push_back(s);
        words.push_back(d);
        for (int i = 0; i < n_pl[t]; i++) words.push_back(p[16*i +: 16]);
        if (CS != 0) begin
            x = '0;
            foreach (words[i]) x = x ^ words[i];
            words.push_back(x);
        end
        foreach (words[i]) begin
            e.w    = words[i];
            e.last = (i == words.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    // Checks every cycle; a word presented with out_ready high transfers on the next posedge.
    always @(negedge clk) begin
        if (!nrst) begin
            exp_q.delete();
            done_due   = 0;
            after_done = 0;
        end else begin
            chk("tx_done", 32'(tx_done), 32'(done_due));
            if (done_due) begin
                chk("done_busy", 32'(tx_busy), 32'd1);
                chk("done_valid", 32'(out_valid), 32'd0);
            end
            if (after_done) chk("post_done_busy", 32'(tx_busy), 32'd0);
            after_done = done_due;
            done_due   = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0].w));
                    chk("out_last", 32'(out_last), 32'(exp_q[0].last));
                    chk("valid_busy", 32'(tx_busy), 32'd1);
                    if (out_ready) begin
                        rx_log.push_back(out_data);
                        if (exp_q[0].last) done_due = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_last", 32'(out_last), 32'd0);
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [15:0] s, input logic [15:0] d,
                        input logic [63:0] p);
        rx_log.delete();
        push_pkt(t, s, d, p);
        tx_type       = t;
        myNodeID      = s;
        destinationID = d;
        payload       = p;
        tx_req        = 1'b1;
        @(posedge clk);
        #1 tx_req = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (tx_done) break;
            cyc++;
            if (cyc > max_cyc) begin
                chk("done_timeout", 32'(cyc), 32'(max_cyc));
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_data"}, 32'(out_data), 32'd0);
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_last"}, 32'(out_last), 32'd0);
        chk({nm, "_busy"}, 32'(tx_busy), 32'd0);
        chk({nm, "_done"}, 32'(tx_done), 32'd0);
        chk({nm, "_err"}, 32'(tx_err), 32'd0);
    endtask

    logic [15:0] hb_exp[7] = '{16'h0007 + 16'(CS), 16'h0005, 16'hFFFF, 16'h0002,
                               16'h0010, 16'h0064, 16'h0020};

    initial begin
        int cyc;
        nrst = 1'b0; tx_req = 1'b0; tx_type = 3'd0; myNodeID = '0;
        destinationID = '0; payload = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 nrst = 1'b1;

        // HB back-to-back: done arrives one negedge per word after the request edge
        @(posedge clk); #1;
        send(3'd0, 16'h0005, 16'hFFFF, 64'h0020_0064_0010_0002);
        wait_done(50, cyc);
        chk("hb_latency", 32'(cyc), 32'(7 + CS));
        chk("hb_len", 32'(rx_log.size()), 32'(7 + CS));
        for (int i = 0; i < 7; i++) begin
            if (i < rx_log.size()) chk("hb_word", 32'(rx_log[i]), 32'(hb_exp[i]));
        end
        @(negedge clk);
        chk("hb_busy_low", 32'(tx_busy), 32'd0);

        // DATA with a 3-cycle stall while W2 is presented
        @(posedge clk); #1;
        send(3'd5, 16'h0003, 16'h0009, 64'h0000_0333_0222_0111);
        @(posedge clk); #1;
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", 32'(out_data), 32'h0009);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(50, cyc);
        chk("data_len", 32'(rx_log.size()), 32'(6 + CS));
        if (rx_log.size() > 0) chk("data_w0", 32'(rx_log[0]), 32'(16'hA006 + 16'(CS)));

        // Invalid type
        @(posedge clk); #1;
        tx_type = 3'b111; tx_req = 1'b1;
        @(posedge clk); #1 tx_req = 1'b0;
        @(negedge clk);
        chk("inv_err", 32'(tx_err), 32'd1);
        chk("inv_valid", 32'(out_valid), 32'd0);
        chk("inv_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        chk("inv_err_pulse", 32'(tx_err), 32'd0);
        chk("inv_busy2", 32'(tx_busy), 32'd0);

        // CHE aborted by reset after W1 transferred, then resent in full
        @(posedge clk); #1;
        send(3'd1, 16'h0011, 16'h0022, 64'h0000_0000_0000_0033);
        @(posedge clk); #1;
        @(posedge clk); #1 nrst = 1'b0;
        chk("abort_sent", 32'(rx_log.size()), 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("abort");
        @(posedge clk); #1 nrst = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        send(3'd1, 16'h0011, 16'h0022, 64'h0000_0000_0000_0033);
        wait_done(50, cyc);
        chk("che_len", 32'(rx_log.size()), 32'(4 + CS));
        if (rx_log.size() > 0) chk("che_w0", 32'(rx_log[0]), 32'(16'h2004 + 16'(CS)));

        // CHT with tx_req held: DONE ignores it, next packet starts 2 cycles after tx_done
        @(posedge clk); #1;
        rx_log.delete();
        push_pkt(3'd4, 16'h0001, 16'h0002, 64'h0000_0000_0000_0044);
        push_pkt(3'd4, 16'h0001, 16'h0002, 64'h0000_0000_0000_0044);
        tx_type = 3'd4; myNodeID = 16'h0001; destinationID = 16'h0002;
        payload = 64'h0000_0000_0000_0044; tx_req = 1'b1;
        wait_done(50, cyc);
        @(negedge clk);
        chk("held_gap_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("held_restart_valid", 32'(out_valid), 32'd1);
        chk("held_restart_w0", 32'(out_data), 32'(16'h8004 + 16'(CS)));
        tx_req = 1'b0;
        wait_done(50, cyc);
        chk("held_len", 32'(rx_log.size()), 32'(2 * (4 + CS)));

`ifdef PKT_CHECKSUM_EN
        // Checksum literal: 0x2005 ^ 3 ^ 3 ^ 3 = 0x2006
        @(posedge clk); #1;
        send(3'd1, 16'h0003, 16'h0003, 64'h0000_0000_0000_0003);
        wait_done(50, cyc);
        chk("cs_len", 32'(rx_log.size()), 32'd5);
        if (rx_log.size() == 5) begin
            chk("cs_w0", 32'(rx_log[0]), 32'h2005);
            chk("cs_w3", 32'(rx_log[3]), 32'h0003);
            chk("cs_sum", 32'(rx_log[4]), 32'h2006);
        end
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
